sha1_digest_store: RTL and testbench

Downstream stage of the SHA-1 core. On a start pulse, driven by the core's `done`, it captures the 160-bit digest and does one of two things through a second DPSRAM port:

- **Store:** writes the digest into memory as five words.
- **Verify:** reads an expected digest from memory and compares it word-by-word against the captured value.

It reports completion and, in verify mode, a per-word mismatch mask and an overall match flag.

---
 rtl/sha1_digest_store_if.sv | 23 ++
 rtl/sha1_digest_store.sv | 163 ++++++++++++++++
 tb/tb_sha1_digest_store.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha1_digest_store_if.sv
// Port-B memory bus between the digest store/verify block and the DPSRAM.
// master: the digest block that drives address/data/write-enable.
// slave: the memory that returns read data.
interface sha1_digest_store_if;
  logic [15:0] port_B_addr;
  logic [31:0] port_B_data_in;
  logic [31:0] port_B_data_out;
  logic        port_B_we;

  modport master (
    output port_B_addr,
    output port_B_data_in,
    output port_B_we,
    input  port_B_data_out
  );

  modport slave (
    input  port_B_addr,
    input  port_B_data_in,
    input  port_B_we,
    output port_B_data_out
  );
endinterface

// File: rtl/sha1_digest_store.sv
// sha1_digest_store: captures a 160-bit SHA-1 digest on start and either
// stores it as five byte-swapped words through DPSRAM port B, or reads five
// words back and compares them, reporting a per-word mismatch mask and a
// match flag.
module sha1_digest_store (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        start,
  input  logic                        mode,
  input  logic [159:0]                hash,
  input  logic [31:0]                 dest_addr,
  output logic                        port_B_clk,
  sha1_digest_store_if.master         mem_b,
  output logic                        busy,
  output logic                        done,
  output logic                        match,
  output logic [4:0]                  mismatch_mask
);

  typedef enum logic [1:0] {IDLE, WRITE, RWAIT, RCMP} state_t;

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [159:0]   hash_q, hash_d;
  logic [15:0]    base_q, base_d;
  logic [15:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           we_q, we_d;
  logic           done_q, done_d;
  logic           match_q, match_d;
  logic [4:0]     mask_q, mask_d;
  logic [15:0]    start_base;
  logic           unused_addr_bits;

  // Memory is word-aligned inside a 64 KiB window; the rest of dest_addr is ignored.
  assign start_base       = {dest_addr[15:2], 2'b00};
  assign unused_addr_bits = ^{dest_addr[31:16], dest_addr[1:0]};

  // H0 sits in the top 32 bits of the digest.
  function automatic logic [31:0] word_sel(input logic [159:0] h, input logic [2:0] i);
    logic [31:0] w;
    case (i)
      3'd0:    w = h[159:128];
      3'd1:    w = h[127:96];
      3'd2:    w = h[95:64];
      3'd3:    w = h[63:32];
      default: w = h[31:0];
    endcase
    return w;
  endfunction

  // Lowest byte address must hold the first digest byte.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Address of word i; wraps modulo 2^16.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] i);
    return base + {11'd0, i, 2'b00};
  endfunction

  assign port_B_clk           = clk;
  assign mem_b.port_B_addr    = addr_q;
  assign mem_b.port_B_data_in = wdata_q;
  assign mem_b.port_B_we      = we_q;
  assign busy                 = (state_q != IDLE);
  assign done                 = done_q;
  assign match                = match_q;
  assign mismatch_mask        = mask_q;

  // State and datapath registers; reset clears everything, dropping we at once.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      hash_q  <= 160'd0;
      base_q  <= 16'd0;
      addr_q  <= 16'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      mask_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hash_q  <= hash_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      match_q <= match_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state and next-output logic for the store/verify sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hash_d  = hash_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    done_d  = done_q;
    match_d = match_q;
    mask_d  = mask_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          hash_d  = hash;
          base_d  = start_base;
          idx_d   = 3'd0;
          done_d  = 1'b0;
          match_d = 1'b0;
          mask_d  = 5'd0;
          addr_d  = start_base;
          if (!mode) begin
            wdata_d = byte_swap(hash[159:128]);
            we_d    = 1'b1;
            state_d = WRITE;
          end else begin
            we_d    = 1'b0;
            state_d = RWAIT;
          end
        end
      end
      WRITE: begin
        if (idx_q != 3'd4) begin
          idx_d   = idx_q + 3'd1;
          addr_d  = word_addr(base_q, idx_d);
          wdata_d = byte_swap(word_sel(hash_q, idx_d));
        end else begin
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      // Read data for the address presented last cycle arrives one edge later.
      RWAIT: begin
        state_d = RCMP;
      end
      RCMP: begin
        if (mem_b.port_B_data_out != byte_swap(word_sel(hash_q, idx_q)))
          mask_d = mask_q | (5'b00001 << idx_q);
        if (idx_q != 3'd4) begin
          idx_d   = idx_q + 3'd1;
          addr_d  = word_addr(base_q, idx_d);
          state_d = RWAIT;
        end else begin
          done_d  = 1'b1;
          match_d = (mask_d == 5'd0);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha1_digest_store.sv
// Testbench for sha1_digest_store: scoreboard of expected memory writes and
// completion results, with a monitor that checks them as the DUT produces them.
module tb_sha1_digest_store;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [159:0] hash = '0;
  logic [31:0]  dest_addr = '0;
  logic         port_B_clk;
  logic         busy, done, match;
  logic [4:0]   mismatch_mask;

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  sha1_digest_store_if bus ();

  sha1_digest_store dut (
    .clk          (clk),
    .nreset       (nreset),
    .start        (start),
    .mode         (mode),
    .hash         (hash),
    .dest_addr    (dest_addr),
    .port_B_clk   (port_B_clk),
    .mem_b        (bus),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .mismatch_mask(mismatch_mask)
  );

  // Synchronous DPSRAM, 1-cycle read latency, with a bench backdoor write port.
  logic [31:0] mem [0:16383];
  logic        bd_we = 1'b0;
  logic [13:0] bd_a = '0;
  logic [31:0] bd_d = '0;

  always @(posedge port_B_clk) begin
    if (bd_we) mem[bd_a] <= bd_d;
    else if (bus.port_B_we) mem[bus.port_B_addr[15:2]] <= bus.port_B_data_in;
    bus.port_B_data_out <= mem[bus.port_B_addr[15:2]];
  end

  typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic m; logic [4:0] mask; logic [7:0] lat; } res_t;
  wr_t  exp_wr[$];
  res_t exp_res[$];

  // Reference model: digest word i, stored with first byte at lowest address.
  function automatic logic [31:0] ref_word(input logic [159:0] h, input int i);
    logic [31:0] w, s;
    w = h[159-32*i -: 32];
    s = {<<8{w}};
    return s;
  endfunction

  function automatic logic [15:0] ref_addr(input logic [31:0] dst, input int i);
    return (dst[15:0] & 16'hFFFC) + 16'(4*i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push the expected outcome of one operation onto the scoreboard.
  task automatic push_op(input logic m, input logic [159:0] h, input logic [31:0] d);
    logic [4:0]  mk;
    logic [15:0] a;
    if (!m) begin
      for (int i = 0; i < 5; i++) exp_wr.push_back('{a: ref_addr(d, i), d: ref_word(h, i)});
      exp_res.push_back('{m: 1'b0, mask: 5'd0, lat: 8'd5});
    end else begin
      mk = '0;
      for (int i = 0; i < 5; i++) begin
        a = ref_addr(d, i);
        if (mem[a[15:2]] !== ref_word(h, i)) mk[i] = 1'b1;
      end
      exp_res.push_back('{m: (mk == 5'd0), mask: mk, lat: 8'd10});
    end
  endtask

  task automatic drive_start(input logic m, input logic [159:0] h, input logic [31:0] d);
    @(negedge clk);
    mode = m; hash = h; dest_addr = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic op(input logic m, input logic [159:0] h, input logic [31:0] d);
    push_op(m, h, d);
    drive_start(m, h, d);
    wait_idle();
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_a = a[15:2]; bd_d = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    {63'd0, bus.port_B_we}, 64'd0);
    chk({tag, "_addr"},  {48'd0, bus.port_B_addr}, 64'd0);
    chk({tag, "_din"},   {32'd0, bus.port_B_data_in}, 64'd0);
    chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
    chk({tag, "_done"},  {63'd0, done}, 64'd0);
    chk({tag, "_match"}, {63'd0, match}, 64'd0);
    chk({tag, "_mask"},  {59'd0, mismatch_mask}, 64'd0);
  endtask

  // Monitor: checks every write and every completion against the scoreboard.
  initial begin
    logic busy_p = 1'b0;
    logic done_p = 1'b0;
    int   lat = 0;
    wr_t  w;
    res_t r;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        busy_p = 1'b0; done_p = 1'b0;
      end else begin
        lat++;
        if (busy && !busy_p) lat = 0;
        if (bus.port_B_we) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", {48'd0, bus.port_B_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", {48'd0, bus.port_B_addr}, {48'd0, w.a});
            chk("wr_data", {32'd0, bus.port_B_data_in}, {32'd0, w.d});
          end
        end
        if (done && !done_p) begin
          if (exp_res.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            r = exp_res.pop_front();
            chk("match", {63'd0, match}, {63'd0, r.m});
            chk("mask", {59'd0, mismatch_mask}, {59'd0, r.mask});
            chk("done_latency", 64'(lat), {56'd0, r.lat});
          end
        end
        busy_p = busy; done_p = done;
      end
    end
  end

  localparam logic [159:0] ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

  initial begin
    logic [159:0] h, h2;
    logic [31:0]  d, d2;
    logic         m;
    logic [4:0]   corrupt;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // 1: store "abc" at 0x100
    op(1'b0, ABC, 32'h0000_0100);
    chk("mem100", {32'd0, mem[14'h40]}, 64'h363e99a9);
    chk("mem104", {32'd0, mem[14'h41]}, 64'h6a810647);
    chk("mem108", {32'd0, mem[14'h42]}, 64'h71253eba);
    chk("mem10c", {32'd0, mem[14'h43]}, 64'h6cc25078);
    chk("mem110", {32'd0, mem[14'h44]}, 64'h9dd8d09c);

    // 2: verify pass against the stored digest
    op(1'b1, ABC, 32'h0000_0100);
    chk("verify_pass_match", {63'd0, match}, 64'd1);

    // 3: verify fail with word 2 cleared
    bd_write(16'h0108, 32'h0);
    op(1'b1, ABC, 32'h0000_0100);
    chk("verify_fail_mask", {59'd0, mismatch_mask}, 64'b00100);

    // 4: wrap-around store
    op(1'b0, {$urandom, $urandom, $urandom, $urandom, $urandom}, 32'h0000_FFFB);

    // 5: start while busy and hash change after capture are ignored
    h = {$urandom, $urandom, $urandom, $urandom, $urandom};
    push_op(1'b0, h, 32'h0000_0200);
    drive_start(1'b0, h, 32'h0000_0200);
    hash = ~h;
    @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ignored_start_busy", {63'd0, busy}, 64'd0);
    chk("ignored_start_wr_q", 64'(exp_wr.size()), 64'd0);

    // Back-to-back: start held through completion is taken on the following cycle
    h = {$urandom, $urandom, $urandom, $urandom, $urandom};
    h2 = {$urandom, $urandom, $urandom, $urandom, $urandom};
    push_op(1'b0, h, 32'h0000_0300);
    @(negedge clk);
    mode = 1'b0; hash = h; dest_addr = 32'h0000_0300; start = 1'b1;
    @(posedge clk); #1;
    hash = h2; dest_addr = 32'h0000_0400;
    push_op(1'b0, h2, 32'h0000_0400);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_e5_busy", {63'd0, busy}, 64'd0);
    chk("b2b_e5_done", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    chk("b2b_e6_busy", {63'd0, busy}, 64'd1);
    chk("b2b_e6_done", {63'd0, done}, 64'd0);
    start = 1'b0;
    wait_idle();

    // 6: reset at E3 of a store; only three writes reach memory
    h = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) exp_wr.push_back('{a: ref_addr(32'h500, i), d: ref_word(h, i)});
    drive_start(1'b0, h, 32'h0000_0500);
    repeat (3) @(posedge clk);
    #1 nreset = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    chk("midreset_wr_q", 64'(exp_wr.size()), 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    op(1'b0, h, 32'h0000_0500);

    // Randomized operations
    for (int k = 0; k < 16; k++) begin
      m = 1'($urandom_range(0, 1));
      h = {$urandom, $urandom, $urandom, $urandom, $urandom};
      d = $urandom;
      if (m && ($urandom_range(0, 3) != 0)) begin
        corrupt = ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'd0;
        for (int i = 0; i < 5; i++) begin
          d2 = corrupt[i] ? ~ref_word(h, i) : ref_word(h, i);
          bd_write(ref_addr(d, i), d2);
        end
      end
      op(m, h, d);
    end

    repeat (4) @(negedge clk);
    chk("final_wr_q", 64'(exp_wr.size()), 64'd0);
    chk("final_res_q", 64'(exp_res.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
